// File: rtl/uart_send_nbyte.sv
// uart_send_nbyte: multi-byte 8N1 UART frame sender with integrated baud timing.
//
// A rising edge on en latches the whole payload and sends TOTAL bytes back to
// back, where TOTAL = NBYTES, plus two (CR, LF) when APPEND_CRLF is set. Each
// byte takes 10*DIV + 1 clocks: start bit, 8 data bits LSB first, stop bit
// (DIV clocks each), then one inter-byte NEXT clock with the line held high.
//
// Start handshake: a message starts only on a rising edge of en seen while
// idle (en & ~en_d). The payload is sampled in that same cycle, busy rises on
// the following cycle, and edges that arrive while busy are dropped, not queued.
// Completion is a one-cycle done or aborted pulse, with busy already low.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous, active-high reset
//   en        start request (rising edge only)
//   data      payload, 8*NBYTES bits, captured on the start cycle
//   abort     level; stop at the next byte boundary (current byte completes)
//   txd       serial line, idle high
//   busy      message in flight
//   byte_idx  index of the byte currently on the line
//   done      one-cycle pulse after a complete message
//   aborted   one-cycle pulse after a message cut short by abort
module uart_send_nbyte #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int NBYTES      = 8,
  parameter int MSB_FIRST   = 1,
  parameter int APPEND_CRLF = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [8*NBYTES-1:0]   data,
  input  logic                  abort,
  output logic                  txd,
  output logic                  busy,
  output logic [5:0]            byte_idx,
  output logic                  done,
  output logic                  aborted
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int TOTAL = NBYTES + 2 * APPEND_CRLF;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_NEXT, S_FIN
  } state_t;

  state_t state, state_nx;

  logic                 en_d;
  logic [8*NBYTES-1:0]  payload;
  logic [DIV_W-1:0]     div_cnt;
  logic [2:0]           bit_cnt;
  logic                 fin_abort;   // remembers why we are in FIN
  logic [7:0]           cur_byte;

  logic start_edge, div_last, last_byte;

  assign start_edge = en & ~en_d;
  assign div_last   = (div_cnt == DIV_W'(DIV - 1));
  assign last_byte  = (byte_idx == 6'(TOTAL - 1));

  // Byte currently on the line; indices past the payload map to CR/LF.
  always_comb begin
    cur_byte = 8'h00;
    for (int k = 0; k < NBYTES; k++) begin
      if (byte_idx == 6'(k)) begin
        if (MSB_FIRST != 0) cur_byte = payload[8*(NBYTES-k)-1 -: 8];
        else                cur_byte = payload[8*k +: 8];
      end
    end
    if (APPEND_CRLF != 0) begin
      if (byte_idx == 6'(NBYTES))     cur_byte = 8'h0D;
      if (byte_idx == 6'(NBYTES + 1)) cur_byte = 8'h0A;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start_edge) state_nx = S_START;
      S_START: if (div_last) state_nx = S_DATA;
      S_DATA:  if (div_last && bit_cnt == 3'd7) state_nx = S_STOP;
      S_STOP:  if (div_last) state_nx = S_NEXT;
      S_NEXT:  state_nx = (abort || last_byte) ? S_FIN : S_START;
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs decoded from state; reset forces IDLE so txd goes high at once.
  always_comb begin
    txd     = 1'b1;
    busy    = 1'b0;
    done    = 1'b0;
    aborted = 1'b0;
    case (state)
      S_START: begin txd = 1'b0; busy = 1'b1; end
      S_DATA:  begin txd = cur_byte[bit_cnt]; busy = 1'b1; end
      S_STOP:  busy = 1'b1;
      S_NEXT:  busy = 1'b1;
      S_FIN:   begin done = ~fin_abort; aborted = fin_abort; end
      default: ;
    endcase
  end

  // Datapath: edge detect, payload capture, baud/bit/byte counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_d      <= 1'b0;
      payload   <= '0;
      byte_idx  <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      fin_abort <= 1'b0;
    end else begin
      en_d <= en;
      case (state)
        S_IDLE: if (start_edge) begin
          payload  <= data;
          byte_idx <= '0;
          div_cnt  <= '0;
          bit_cnt  <= '0;
        end
        S_START, S_STOP: div_cnt <= div_last ? '0 : div_cnt + 1'b1;
        S_DATA: begin
          div_cnt <= div_last ? '0 : div_cnt + 1'b1;
          if (div_last) bit_cnt <= bit_cnt + 1'b1;  // wraps to 0 after bit 7
        end
        S_NEXT: begin
          fin_abort <= abort;
          if (!abort && !last_byte) byte_idx <= byte_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
